// File: rtl/prbs8_checker.sv
// prbs8_checker
//   Receive-side checker for the 8-bit LFSR pattern generator. It seeds itself from
//   the received state word, confirms a run of correct predictions, and then locks.
//   While locked it flywheels the expected sequence and counts word and bit errors.
//
//   Sequence: next(s) = {s[7]^s[5]^s[4]^s[3], s[7:1]}. 0x00 is the lock-up word
//   and is never used as a seed.
//
// Ports
//   CLK           in   clock, rising edge
//   RESET         in   synchronous, active-high reset
//   I             in   received LFSR state word
//   I_VALID       in   I is sampled only when high; nothing advances otherwise
//   CLR_COUNT     in   synchronous clear of both error counters
//   LOCKED        out  high while in the locked state
//   ERR           out  one-cycle pulse per mismatched valid word while locked
//   ERR_COUNT     out  saturating count of mismatched words
//   BIT_ERR_COUNT out  saturating count of mismatched bits
module prbs8_checker #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       I,
    input  logic             I_VALID,
    input  logic             CLR_COUNT,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [CNT_W-1:0] BIT_ERR_COUNT
);

    typedef enum logic [1:0] {
        StHunt,
        StSync,
        StLocked
    } state_e;

    // Sum width leaves room for a full 8-bit popcount on top of a narrow counter.
    localparam int unsigned SumW = ((CNT_W > 4) ? CNT_W : 4) + 1;
    localparam logic [SumW-1:0] CntMax = SumW'({CNT_W{1'b1}});

    function automatic logic [7:0] prbs_next(input logic [7:0] s);
        return {s[7] ^ s[5] ^ s[4] ^ s[3], s[7:1]};
    endfunction

    state_e           state_q;
    logic [7:0]       exp_q;
    logic [3:0]       match_q;
    logic [3:0]       miss_q;
    logic             locked_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic [7:0]      diff;
    logic [3:0]      bit_errs;
    logic            count_err;
    logic [SumW-1:0] bit_sum;

    always_comb begin
        diff     = I ^ exp_q;
        bit_errs = '0;
        for (int k = 0; k < 8; k++) begin
            bit_errs = bit_errs + {3'b000, diff[k]};
        end
        count_err = I_VALID && (state_q == StLocked) && (diff != 8'h00);
    end

    // Saturating next values; only applied when count_err is set.
    always_comb begin
        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        bit_sum   = SumW'(bit_cnt_q) + SumW'(bit_errs);
        bit_cnt_d = (bit_sum > CntMax) ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StHunt;
            exp_q    <= 8'h00;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (I_VALID) begin
                case (state_q)
                    StHunt: begin
                        if (I != 8'h00) begin
                            exp_q   <= prbs_next(I);
                            match_q <= '0;
                            state_q <= StSync;
                        end
                    end
                    StSync: begin
                        if (I == exp_q) begin
                            exp_q   <= prbs_next(exp_q);
                            match_q <= match_q + 4'd1;
                            if (match_q + 4'd1 == 4'(LOCK_COUNT)) begin
                                state_q  <= StLocked;
                                miss_q   <= '0;
                                locked_q <= 1'b1;
                            end
                        end else if (I != 8'h00) begin
                            // Reseed from the received word and restart the run.
                            exp_q   <= prbs_next(I);
                            match_q <= '0;
                        end else begin
                            state_q <= StHunt;
                        end
                    end
                    StLocked: begin
                        // Flywheel: the received word is never reloaded while locked.
                        exp_q <= prbs_next(exp_q);
                        if (I == exp_q) begin
                            miss_q <= '0;
                        end else begin
                            err_q  <= 1'b1;
                            miss_q <= miss_q + 4'd1;
                            if (miss_q + 4'd1 == 4'(UNLOCK_COUNT)) begin
                                state_q  <= StHunt;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= StHunt;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Counters persist across unlock/relock; CLR_COUNT beats a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (RESET || CLR_COUNT) begin
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (count_err) begin
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign LOCKED        = locked_q;
    assign ERR           = err_q;
    assign ERR_COUNT     = err_cnt_q;
    assign BIT_ERR_COUNT = bit_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Self-checking bench for prbs8_checker: directed test-plan scenarios followed by a
// randomized link stream. Two instances share stimulus: default counter width and
// a 4-bit counter width for saturation.
module tb_prbs8_checker;

    localparam int LockN   = 4;
    localparam int UnlockN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid = 1'b0;
    logic        clr = 1'b0;

    logic        locked, err, locked4, err4;
    logic [15:0] ec, bc;
    logic [3:0]  ec4, bc4;

    always #5 clk = ~clk;

    prbs8_checker #(.LOCK_COUNT(LockN), .UNLOCK_COUNT(UnlockN), .CNT_W(16)) dut (
        .CLK(clk), .RESET(rst), .I(i_data), .I_VALID(i_valid), .CLR_COUNT(clr),
        .LOCKED(locked), .ERR(err), .ERR_COUNT(ec), .BIT_ERR_COUNT(bc)
    );

    prbs8_checker #(.LOCK_COUNT(LockN), .UNLOCK_COUNT(UnlockN), .CNT_W(4)) dut_w4 (
        .CLK(clk), .RESET(rst), .I(i_data), .I_VALID(i_valid), .CLR_COUNT(clr),
        .LOCKED(locked4), .ERR(err4), .ERR_COUNT(ec4), .BIT_ERR_COUNT(bc4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 = hunt, 1 = sync, 2 = locked.
    int         m_state = 0;
    logic [7:0] m_exp = 8'h00;
    int         m_match = 0;
    int         m_miss = 0;
    bit         m_err = 0;
    int         m_ec = 0, m_bc = 0, m_ec4 = 0, m_bc4 = 0;

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        int fb;
        fb = $countones(s & 8'hB8) % 2;
        return 8'((fb << 7) | (int'(s) >> 1));
    endfunction

    function automatic int sat_add(input int v, input int a, input int max);
        return (v + a > max) ? max : v + a;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c);
        int         add_w = 0;
        int         add_b = 0;
        logic [7:0] old;
        if (r) begin
            m_state = 0; m_exp = 8'h00; m_match = 0; m_miss = 0; m_err = 0;
            m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
            return;
        end
        m_err = 0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 8'h00) begin
                    m_exp = ref_next(d); m_match = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_exp = ref_next(m_exp);
                    m_match++;
                    if (m_match == LockN) begin
                        m_state = 2; m_miss = 0;
                    end
                end else if (d != 8'h00) begin
                    m_exp = ref_next(d); m_match = 0;
                end else begin
                    m_state = 0;
                end
            end else begin
                old   = m_exp;
                m_exp = ref_next(old);
                if (d == old) begin
                    m_miss = 0;
                end else begin
                    m_err = 1;
                    add_w = 1;
                    add_b = $countones(d ^ old);
                    m_miss++;
                    if (m_miss == UnlockN) m_state = 0;
                end
            end
        end
        if (c) begin
            m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
        end else begin
            m_ec  = sat_add(m_ec, add_w, 65535);
            m_bc  = sat_add(m_bc, add_b, 65535);
            m_ec4 = sat_add(m_ec4, add_w, 15);
            m_bc4 = sat_add(m_bc4, add_b, 15);
        end
    endtask

    task automatic compare_all();
        check_val("locked", 32'(locked), 32'(m_state == 2));
        check_val("err", 32'(err), 32'(m_err));
        check_val("err_count", 32'(ec), 32'(m_ec));
        check_val("bit_err_count", 32'(bc), 32'(m_bc));
        check_val("locked_w4", 32'(locked4), 32'(m_state == 2));
        check_val("err_w4", 32'(err4), 32'(m_err));
        check_val("err_count_w4", 32'(ec4), 32'(m_ec4));
        check_val("bit_err_count_w4", 32'(bc4), 32'(m_bc4));
    endtask

    // One clock: drive on the falling edge, model on the rising edge, sample 1 ns later.
    task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit c);
        @(negedge clk);
        rst = r; i_valid = v; i_data = d; clr = c;
        @(posedge clk);
        model_step(r, v, d, c);
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] g;
        logic [7:0] d;
        logic [7:0] lock_seq [5];
        lock_seq[0] = 8'h80; lock_seq[1] = 8'hC0; lock_seq[2] = 8'hE0;
        lock_seq[3] = 8'h70; lock_seq[4] = 8'h38;

        // Reset state
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        check_val("reset_locked", 32'(locked), 32'd0);
        check_val("reset_err_count", 32'(ec), 32'd0);

        // Zeros in hunt never seed
        for (int k = 0; k < 3; k++) cycle(0, 1, 8'h00, 0);
        check_val("zero_hunt_locked", 32'(locked), 32'd0);

        // Clean lock
        for (int k = 0; k < 5; k++) begin
            if (k == 4) check_val("not_locked_before_5th", 32'(locked), 32'd0);
            cycle(0, 1, lock_seq[k], 0);
        end
        check_val("lock_after_0x38", 32'(locked), 32'd1);
        check_val("lock_err_count", 32'(ec), 32'd0);

        // Single error while locked (expected 0x9C)
        cycle(0, 1, 8'h99, 0);
        check_val("err_pulse", 32'(err), 32'd1);
        check_val("err_count_1", 32'(ec), 32'd1);
        check_val("bit_err_count_2", 32'(bc), 32'd2);
        check_val("still_locked", 32'(locked), 32'd1);
        cycle(0, 1, 8'hCE, 0);
        check_val("flywheel_no_err", 32'(err), 32'd0);

        // Unlock after three misses
        for (int k = 0; k < 3; k++) cycle(0, 1, m_exp ^ 8'h01, 0);
        check_val("unlocked", 32'(locked), 32'd0);
        check_val("err_count_4", 32'(ec), 32'd4);

        // Relock with invalid gaps carrying garbage
        w = 8'h80;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, w, 0);
            cycle(0, 0, 8'($urandom), 0);
            cycle(0, 0, 8'h00, 0);
            w = ref_next(w);
        end
        check_val("relock_gaps", 32'(locked), 32'd1);

        // Clear beats same-cycle error; ERR still pulses
        cycle(0, 1, m_exp ^ 8'hFF, 1);
        check_val("clr_err_pulse", 32'(err), 32'd1);
        check_val("clr_err_count", 32'(ec), 32'd0);
        check_val("clr_bit_count", 32'(bc), 32'd0);

        // Saturation of the 4-bit counters
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, m_exp ^ 8'h10, 0);
            cycle(0, 1, m_exp, 0);
        end
        check_val("sat_err_count_w4", 32'(ec4), 32'd15);
        check_val("err_count_20", 32'(ec), 32'd20);

        // Reset mid-lock
        cycle(1, 0, 8'h00, 0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_err_count", 32'(ec), 32'd0);
        check_val("rst_bit_count", 32'(bc), 32'd0);

        // Randomized link stream with errors, zeros, gaps, clears and rare resets
        g = 8'($urandom_range(1, 255));
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit v, c, rr;
            r  = int'($urandom_range(0, 99));
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 59) == 0);
            rr = ($urandom_range(0, 399) == 0);
            if (r < 8)       d = g ^ 8'($urandom_range(1, 255));
            else if (r < 11) d = 8'h00;
            else             d = g;
            cycle(rr, v, d, c);
            if (v) g = ref_next(g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
